// File: rtl/rr_handshake_mux.sv
// N-input registered round-robin arbitrating mux with valid/ready on every channel.
// Optional burst locking is compiled in with the RR_MUX_LOCK_EN macro (adds port in_lock).
module rr_handshake_mux #(
   parameter int WIDTH      = 16,
   parameter int NUM_INPUTS = 4,
   localparam int SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_INPUTS-1:0]       in_valid,
   input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
   output logic [NUM_INPUTS-1:0]       in_ready,
`ifdef RR_MUX_LOCK_EN
   input  logic                        in_lock,
`endif
   input  logic                        force_en,
   input  logic [SEL_W-1:0]            force_sel,
   output logic                        out_valid,
   output logic [WIDTH-1:0]            out_data,
   output logic [SEL_W-1:0]            out_src,
   input  logic                        out_ready
);

   // Handshake: a word moves on a channel in any cycle where valid && ready are both
   // high at the rising edge; a source holds valid and data stable until that happens.

   logic [SEL_W-1:0]      ptr;
   logic                  load_en;
   logic [NUM_INPUTS-1:0] cand;
   logic                  win_found;
   logic [SEL_W-1:0]      win_idx;
   logic                  take;
   logic [WIDTH-1:0]      win_word;
   logic                  lock_active;
   logic [SEL_W-1:0]      lock_src;
   logic                  forced_mode;

   assign load_en     = !out_valid || out_ready;
   assign forced_mode = force_en && !lock_active;

   always_comb begin
      cand = '0;
      if (lock_active) begin
         cand[lock_src] = in_valid[lock_src];
      end else if (force_en) begin
         if ({1'b0, force_sel} < NUM_INPUTS[SEL_W:0])
            cand[force_sel] = in_valid[force_sel];
      end else begin
         cand = in_valid;
      end
   end

   // Search starts just past the last normal-mode winner, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NUM_INPUTS; k++) begin
         if (!win_found && cand[(int'(ptr) + k) % NUM_INPUTS]) begin
            win_found = 1'b1;
            win_idx   = SEL_W'((int'(ptr) + k) % NUM_INPUTS);
         end
      end
   end

   assign take     = win_found && load_en && !rst;
   assign win_word = in_data[win_idx*WIDTH +: WIDTH];

   always_comb begin
      in_ready = '0;
      if (take)
         in_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= SEL_W'(NUM_INPUTS - 1);
      end else if (load_en) begin
         if (take) begin
            out_valid <= 1'b1;
            out_data  <= win_word;
            out_src   <= win_idx;
            if (!forced_mode)
               ptr <= win_idx;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef RR_MUX_LOCK_EN
   // A locked burst ends with the first beat from the lock owner that drops in_lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_active <= 1'b0;
         lock_src    <= '0;
      end else if (take) begin
         if (in_lock) begin
            lock_active <= 1'b1;
            lock_src    <= win_idx;
         end else begin
            lock_active <= 1'b0;
         end
      end
   end
`else
   assign lock_active = 1'b0;
   assign lock_src    = '0;
`endif

endmodule

// File: tb/tb_rr_handshake_mux.sv
// Directed self-checking bench for rr_handshake_mux (4 sources, 16-bit words).
module tb_rr_handshake_mux;

   localparam int W = 16;
   localparam int N = 4;
   localparam int S = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           force_en;
   logic [S-1:0]   force_sel;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [S-1:0]   out_src;
   logic           out_ready;
`ifdef RR_MUX_LOCK_EN
   logic           in_lock;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_handshake_mux #(.WIDTH(W), .NUM_INPUTS(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
      .in_lock   (in_lock),
`endif
      .force_en  (force_en),
      .force_sel (force_sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int i, input logic [W-1:0] v);
      in_data[i*W +: W] = v;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic check_out(input string name, input logic ev, input logic [W-1:0] ed,
                            input logic [S-1:0] es);
      checks++;
      if (out_valid !== ev || out_data !== ed || out_src !== es) begin
         failures++;
         $display("FAIL %s: got valid=%0b data=%h src=%0d, want valid=%0b data=%h src=%0d",
                  name, out_valid, out_data, out_src, ev, ed, es);
      end
   endtask

   task automatic check_ready(input string name, input logic [N-1:0] er);
      checks++;
      if (in_ready !== er) begin
         failures++;
         $display("FAIL %s: got in_ready=%b, want %b", name, in_ready, er);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      step();
      step();
      #1;
      check_ready("reset_ready", 4'b0000);
      check_out("reset_out", 1'b0, 16'h0000, 2'd0);
      rst      = 1'b0;
      in_valid = '0;
      step();
   endtask

   task automatic test_single();
      do_reset();
      set_word(2, 16'hBEEF);
      in_valid  = 4'b0100;
      out_ready = 1'b1;
      #1;
      check_ready("single_ready", 4'b0100);
      step();
      in_valid = '0;
      check_out("single_out", 1'b1, 16'hBEEF, 2'd2);
      step();
      check_out("single_drain", 1'b0, 16'hBEEF, 2'd2);
   endtask

   task automatic test_fairness();
      do_reset();
      for (int i = 0; i < N; i++) set_word(i, 16'(16'h1000 + i));
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check_ready($sformatf("fair_ready_%0d", k), 4'(1 << (k % N)));
         step();
         check_out($sformatf("fair_out_%0d", k), 1'b1, 16'(16'h1000 + (k % N)), 2'(k % N));
      end
   endtask

   // Runs straight after fairness: output holds source 3, pointer at 3.
   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_ready($sformatf("bp_ready_%0d", k), 4'b0000);
         step();
         check_out($sformatf("bp_hold_%0d", k), 1'b1, 16'h1003, 2'd3);
      end
      out_ready = 1'b1;
      #1;
      check_ready("bp_release_ready", 4'b0001);
      step();
      check_out("bp_release_out", 1'b1, 16'h1000, 2'd0);
   endtask

   task automatic test_force();
      do_reset();
      out_ready = 1'b1;
      force_en  = 1'b1;
      force_sel = 2'd3;
      in_valid  = 4'b1011;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_ready($sformatf("force_ready_%0d", k), 4'b1000);
         step();
         check_out($sformatf("force_out_%0d", k), 1'b1, 16'h1003, 2'd3);
      end
      force_en = 1'b0;
      #1;
      check_ready("unforce_ready", 4'b0001);
      step();
      check_out("unforce_out", 1'b1, 16'h1000, 2'd0);
      force_en = 1'b1;
      in_valid = 4'b0011;
      #1;
      check_ready("force_idle_ready", 4'b0000);
      step();
      check_out("force_idle_out", 1'b0, 16'h1000, 2'd0);
      force_en = 1'b0;
      in_valid = '0;
   endtask

   task automatic test_reset_mid_stream();
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      step();
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL mid_pre_valid: got %0b, want 1", out_valid);
      end
      rst = 1'b1;
      #1;
      check_ready("mid_rst_ready", 4'b0000);
      step();
      check_out("mid_rst_out", 1'b0, 16'h0000, 2'd0);
      rst = 1'b0;
      #1;
      check_ready("mid_first_ready", 4'b0001);
      step();
      check_out("mid_first_out", 1'b1, 16'h1000, 2'd0);
      in_valid = '0;
      step();
   endtask

`ifdef RR_MUX_LOCK_EN
   task automatic test_lock();
      do_reset();
      out_ready = 1'b1;
      in_lock   = 1'b0;
      in_valid  = 4'b0001;
      step();
      check_out("lock_pre", 1'b1, 16'h1000, 2'd0);
      in_valid = 4'b0111;
      for (int b = 0; b < 3; b++) begin
         set_word(1, 16'(16'h2000 + b));
         in_lock = (b < 2);
         #1;
         check_ready($sformatf("lock_ready_%0d", b), 4'b0010);
         step();
         check_out($sformatf("lock_out_%0d", b), 1'b1, 16'(16'h2000 + b), 2'd1);
      end
      in_lock = 1'b0;
      step();
      check_out("lock_after", 1'b1, 16'h1002, 2'd2);
      in_valid = '0;
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      force_en  = 1'b0;
      force_sel = '0;
      out_ready = 1'b0;
`ifdef RR_MUX_LOCK_EN
      in_lock   = 1'b0;
`endif
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_force();
      test_reset_mid_stream();
`ifdef RR_MUX_LOCK_EN
      test_lock();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_handshake_mux.md
Name: rr_handshake_mux

Overview:
- Parametrised N-input, registered, round-robin arbitrating multiplexer.
- Each source has a valid/ready handshake. The winner's word is registered onto a single valid/ready output channel.
- Successor to the fixed 4:1 combinational select mux. Used where several CPU units (fetch, load/store, DMA) share one address or data path.
- Includes a forced-select mode that behaves as a plain registered mux.

Parameters:
- WIDTH, 16, bit width of each data word.
- NUM_INPUTS, 4, number of source channels (2..16).
- SEL_W, $clog2(NUM_INPUTS) (minimum 1), derived local parameter: width of the select and source index.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  NUM_INPUTS  per-source request; bit i belongs to source i.
- in_data  input  NUM_INPUTS*WIDTH  packed source words; source i is bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_INPUTS  per-source accept; at most one bit is high.
- force_en  input  1  when 1, only force_sel may be granted.
- force_sel  input  SEL_W  source index used when force_en=1.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered word.
- out_src  output  SEL_W  index of the source that produced out_data.
- out_ready  input  1  downstream accept.

Behaviour:
- load_en = !out_valid || out_ready. The output register may take a new word this cycle.
- Candidate set:
  - force_en=0: all i with in_valid[i]=1.
  - force_en=1: only force_sel, and only if in_valid[force_sel]=1.
  - force_en=1 with force_sel >= NUM_INPUTS: no candidate.
- Winner (round-robin): the first candidate found searching from ptr+1 upward, wrapping modulo NUM_INPUTS.
- in_ready[winner] = load_en (combinational). All other in_ready bits are 0. in_ready is all-zero when there is no candidate.
- Transfer on source i: in_valid[i] && in_ready[i]. At the next clock edge:
  - out_data <= in_data[i]
  - out_src <= i
  - out_valid <= 1
- ptr update:
  - Normal mode: ptr <= i.
  - Forced mode: ptr is unchanged.
- If load_en=1 and there is no candidate: out_valid <= 0. out_data and out_src hold their values.
- If load_en=0 (out_valid=1, out_ready=0): the output register holds; all in_ready = 0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word per cycle when out_ready stays high.
- Simultaneous drain and load in the same cycle is allowed: out_ready=1 and a new transfer → no bubble.
- Source rule: while in_valid[i]=1 and no transfer has occurred, in_valid[i] and that source's data stay stable. The block relies on this and does not check it.
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_src=0.
  - ptr=NUM_INPUTS-1, so source 0 has first priority.
  - All in_ready=0 during the reset cycle.
  - A word held in the output register when reset occurs is discarded.
- Fairness: with all sources requesting continuously and force_en=0, grants go 0,1,..,N-1,0,…

Optional Feature:
- Macro: RR_MUX_LOCK_EN.
- When defined:
  - Adds input port in_lock (width 1), sampled together with the transfer.
  - A transfer with in_lock=1 sets lock_active=1 and lock_src=winner.
  - While lock_active=1, the candidate set is restricted to lock_src. force_en is ignored.
  - A transfer from lock_src with in_lock=0 clears lock_active. That transfer is the final beat of the locked burst.
  - Reset clears lock_active.
- When not defined:
  - The in_lock port is absent.
  - Pure round-robin / forced behaviour as described above.

Test Plan:
- Reset then single request: in_valid=4'b0100, data2=16'hBEEF, out_ready=1 → in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=16'hBEEF, out_src=2.
- Fairness: in_valid=4'b1111 held for 8 cycles, out_ready=1 → out_src sequence 0,1,2,3,0,1,2,3; one in_ready bit per cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while sources request → in_ready=0; out_data stable. Release out_ready → the next winner loads the following cycle with no bubble.
- Force mode: force_en=1, force_sel=3, in_valid=4'b1011 → only source 3 granted, repeatedly; ptr unchanged. Then force_en=0 → next grant is source 0. Also force_sel=3 with in_valid[3]=0 → no grant, out_valid drops after drain.
- Reset mid-stream: rst=1 while out_valid=1 and in_valid=4'b1111 → next cycle out_valid=0, out_data=0; after release the first grant is source 0.
- RR_MUX_LOCK_EN: source 1 sends 3 beats with in_lock=1,1,0 while source 0 and source 2 request → out_src=1,1,1, then 2 (ptr=1, lock cleared).
